axi_modport_slave: RTL and testbench



---
 rtl/axi_slave_pkg.sv | 27 ++
 rtl/axi_slave_ram.sv | 33 +++
 rtl/axi_modport_slave.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi_modport_slave.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_pkg.sv
// Shared types, response codes and burst validation for the AXI memory slave.
package axi_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    // A burst is rejected when its beat size exceeds the bus, its last beat
    // lands outside the RAM, or it straddles a 4 KiB page. Addresses are
    // carried in 33 bits so a carry out of the address space shows up as a
    // page change and an out-of-range address.
    function automatic logic burst_err(
        input logic [32:0] start,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [2:0]  max_size,
        input logic [32:0] mem_bytes
    );
        logic [32:0] last;
        last = start + ({25'd0, len} << size);
        return (size > max_size) || (last >= mem_bytes) ||
               (start[32:12] != last[32:12]);
    endfunction

endpackage

// File: rtl/axi_slave_ram.sv
// Word-organised RAM: one write port, one registered read port, read-before-write.
module axi_slave_ram
    import axi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned IW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [IW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register only updates when a new beat is fetched, so it holds
    // through stalls; a same-cycle write is seen on the following read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_modport_slave.sv
// AXI4 INCR-burst slave in front of an internal RAM; write and read channels
// run fully independently.
module axi_modport_slave
    import axi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned MEMORY_DEPTH = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESTN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVAILD,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVAILD,
    input  logic                  RREADY
);

    localparam int unsigned WL2 = $clog2(DATA_WIDTH/8);
    localparam int unsigned IW  = $clog2(MEMORY_DEPTH);
    localparam int unsigned AW1 = ADDR_WIDTH + 1;
    localparam logic [32:0] MEM_BYTES = 33'(MEMORY_DEPTH * (DATA_WIDTH/8));

    function automatic logic [IW-1:0] widx(input logic [AW1-1:0] a);
        return IW'(a >> WL2);
    endfunction

    wstate_t        w_state, w_state_n;
    logic           awready_n, wready_n, bvalid_n;
    logic [1:0]     bresp_n;
    logic [AW1-1:0] w_addr, w_addr_n;
    logic [7:0]     w_len, w_len_n, w_beat, w_beat_n;
    logic [2:0]     w_size, w_size_n;
    logic           w_err, w_err_n, w_lerr, w_lerr_n, w_mis;
    logic           ram_we;

    rstate_t        r_state, r_state_n;
    logic           arready_n, rvalid_n, rlast_n;
    logic [1:0]     rresp_n;
    logic [AW1-1:0] r_addr, r_addr_n;
    logic [7:0]     r_len, r_len_n, r_beat, r_beat_n;
    logic [2:0]     r_size, r_size_n;
    logic           r_err, r_err_n;
    logic           ram_re;
    logic [IW-1:0]  ram_raddr;
    logic [DATA_WIDTH-1:0] ram_q;

    // Write channel next-state, registered-output and RAM write-port logic.
    always_comb begin
        w_state_n = w_state;
        awready_n = AWREADY;
        wready_n  = WREADY;
        bvalid_n  = BVAILD;
        bresp_n   = BRESP;
        w_addr_n  = w_addr;
        w_len_n   = w_len;
        w_size_n  = w_size;
        w_beat_n  = w_beat;
        w_err_n   = w_err;
        w_lerr_n  = w_lerr;
        ram_we    = 1'b0;
        w_mis     = WLAST != (w_beat == w_len);
        case (w_state)
            W_IDLE: begin
                awready_n = 1'b1;
                if (AWVALID && AWREADY) begin
                    w_addr_n  = AW1'(AWADDR);
                    w_len_n   = AWLEN;
                    w_size_n  = AWSIZE;
                    w_beat_n  = '0;
                    w_err_n   = burst_err(33'(AWADDR), AWLEN, AWSIZE, 3'(WL2), MEM_BYTES);
                    w_lerr_n  = 1'b0;
                    awready_n = 1'b0;
                    wready_n  = 1'b1;
                    w_state_n = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && WREADY) begin
                    ram_we   = !w_err;
                    w_addr_n = w_addr + (AW1'(1) << w_size);
                    w_beat_n = w_beat + 8'd1;
                    if (w_mis) w_lerr_n = 1'b1;
                    if (w_beat == w_len) begin
                        wready_n  = 1'b0;
                        bvalid_n  = 1'b1;
                        bresp_n   = (w_err || w_lerr || w_mis) ? RESP_SLVERR : RESP_OKAY;
                        w_state_n = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (BVAILD && BREADY) begin
                    bvalid_n  = 1'b0;
                    bresp_n   = RESP_OKAY;
                    awready_n = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // Write channel state and output registers.
    always_ff @(posedge ACLK or posedge ARESTN) begin
        if (ARESTN) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVAILD  <= 1'b0;
            BRESP   <= RESP_OKAY;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
            w_lerr  <= 1'b0;
        end else begin
            w_state <= w_state_n;
            AWREADY <= awready_n;
            WREADY  <= wready_n;
            BVAILD  <= bvalid_n;
            BRESP   <= bresp_n;
            w_addr  <= w_addr_n;
            w_len   <= w_len_n;
            w_size  <= w_size_n;
            w_beat  <= w_beat_n;
            w_err   <= w_err_n;
            w_lerr  <= w_lerr_n;
        end
    end

    // Read channel next-state logic; the RAM fetch for the next beat is issued
    // on the handshake so data is ready in the cycle that RVAILD is presented.
    always_comb begin
        r_state_n = r_state;
        arready_n = ARREADY;
        rvalid_n  = RVAILD;
        rlast_n   = RLAST;
        rresp_n   = RRESP;
        r_addr_n  = r_addr;
        r_len_n   = r_len;
        r_size_n  = r_size;
        r_beat_n  = r_beat;
        r_err_n   = r_err;
        ram_re    = 1'b0;
        ram_raddr = widx(r_addr);
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (ARVALID && ARREADY) begin
                    r_addr_n  = AW1'(ARADDR);
                    r_len_n   = ARLEN;
                    r_size_n  = ARSIZE;
                    r_beat_n  = '0;
                    r_err_n   = burst_err(33'(ARADDR), ARLEN, ARSIZE, 3'(WL2), MEM_BYTES);
                    ram_re    = 1'b1;
                    ram_raddr = widx(AW1'(ARADDR));
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rlast_n   = (ARLEN == 8'd0);
                    rresp_n   = r_err_n ? RESP_SLVERR : RESP_OKAY;
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (RVAILD && RREADY) begin
                    if (RLAST) begin
                        rvalid_n  = 1'b0;
                        rlast_n   = 1'b0;
                        rresp_n   = RESP_OKAY;
                        arready_n = 1'b1;
                        r_state_n = R_IDLE;
                    end else begin
                        r_addr_n  = r_addr + (AW1'(1) << r_size);
                        r_beat_n  = r_beat + 8'd1;
                        ram_re    = 1'b1;
                        ram_raddr = widx(r_addr_n);
                        rlast_n   = (r_beat_n == r_len);
                    end
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // Read channel state and output registers.
    always_ff @(posedge ACLK or posedge ARESTN) begin
        if (ARESTN) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVAILD  <= 1'b0;
            RLAST   <= 1'b0;
            RRESP   <= RESP_OKAY;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= r_state_n;
            ARREADY <= arready_n;
            RVAILD  <= rvalid_n;
            RLAST   <= rlast_n;
            RRESP   <= rresp_n;
            r_addr  <= r_addr_n;
            r_len   <= r_len_n;
            r_size  <= r_size_n;
            r_beat  <= r_beat_n;
            r_err   <= r_err_n;
        end
    end

    // Error bursts return zero data; both mux inputs come straight from registers.
    assign RDATA = r_err ? '0 : ram_q;

    axi_slave_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (MEMORY_DEPTH)
    ) u_ram (
        .clk  (ACLK),
        .rst  (ARESTN),
        .we   (ram_we),
        .waddr(widx(w_addr)),
        .wdata(WDATA),
        .re   (ram_re),
        .raddr(ram_raddr),
        .rdata(ram_q)
    );

endmodule

// File: tb/tb_axi_modport_slave.sv
// Directed self-checking bench for axi_modport_slave.
module tb_axi_modport_slave;

    logic        ACLK;
    logic        ARESTN;
    logic [15:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVAILD;
    logic        BREADY;
    logic [15:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVAILD;
    logic        RREADY;

    int tests = 0;
    int fails = 0;
    logic [31:0] wdat [256];
    logic [31:0] rexp [256];

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    axi_modport_slave #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (16),
        .MEMORY_DEPTH(1024)
    ) dut (
        .ACLK(ACLK), .ARESTN(ARESTN),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVAILD(BVAILD), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVAILD(RVAILD), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] l, input int early,
                            input logic [1:0] er, input string tag);
        int n;
        AWADDR = a; AWLEN = l; AWSIZE = 3'd2; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin tick(); n++; end
        chk({tag, "_aw_wait"}, 32'(n < 50), 32'd1);
        tick();
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            WDATA  = wdat[i];
            WLAST  = (early >= 0) ? (i == early) : (i == int'(l));
            WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin tick(); n++; end
            chk({tag, "_w_wait"}, 32'(n < 50), 32'd1);
            tick();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b1;
        n = 0;
        while (!BVAILD && n < 50) begin tick(); n++; end
        chk({tag, "_b_wait"}, 32'(n < 50), 32'd1);
        chk({tag, "_bresp"}, 32'(BRESP), 32'(er));
        tick();
        BREADY = 1'b0;
        chk({tag, "_b_done"}, 32'(BVAILD), 32'd0);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] l, input logic [2:0] sz,
                           input bit stall, input logic [1:0] er, input string tag);
        int n;
        ARADDR = a; ARLEN = l; ARSIZE = sz; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin tick(); n++; end
        chk({tag, "_ar_wait"}, 32'(n < 50), 32'd1);
        tick();
        ARVALID = 1'b0;
        RREADY = !stall;
        for (int i = 0; i <= int'(l); i++) begin
            n = 0;
            while (!RVAILD && n < 50) begin tick(); n++; end
            chk({tag, "_r_wait"}, 32'(n < 50), 32'd1);
            if (stall) begin
                RREADY = 1'b0;
                tick();
                chk({tag, "_stall_data"}, RDATA, rexp[i]);
                chk({tag, "_stall_last"}, 32'(RLAST), 32'(i == int'(l)));
                RREADY = 1'b1;
            end
            chk({tag, "_rdata"}, RDATA, rexp[i]);
            chk({tag, "_rresp"}, 32'(RRESP), 32'(er));
            chk({tag, "_rlast"}, 32'(RLAST), 32'(i == int'(l)));
            tick();
        end
        RREADY = 1'b0;
        chk({tag, "_r_done"}, 32'(RVAILD), 32'd0);
    endtask

    initial begin
        int n;
        AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWVALID = 1'b0;
        WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARVALID = 1'b0; RREADY = 1'b0;
        ARESTN = 1'b1;

        // Reset state
        #12;
        chk("rst_awready", 32'(AWREADY), 32'd0);
        chk("rst_arready", 32'(ARREADY), 32'd0);
        chk("rst_wready",  32'(WREADY),  32'd0);
        chk("rst_bvalid",  32'(BVAILD),  32'd0);
        chk("rst_rvalid",  32'(RVAILD),  32'd0);
        chk("rst_rlast",   32'(RLAST),   32'd0);
        chk("rst_rdata",   RDATA,        32'd0);
        chk("rst_resp",    32'({BRESP, RRESP}), 32'd0);
        tick();
        ARESTN = 1'b0;
        tick();
        chk("post_rst_awready", 32'(AWREADY), 32'd1);
        chk("post_rst_arready", 32'(ARREADY), 32'd1);

        // Single-beat write and read-back
        wdat[0] = 32'hDEADBEEF;
        do_write(16'h0010, 8'd0, -1, OK, "t1w");
        rexp[0] = 32'hDEADBEEF;
        do_read(16'h0010, 8'd0, 3'd2, 1'b0, OK, "t1r");

        // Four-beat burst, read back with a stall on every beat
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        do_write(16'h0100, 8'd3, -1, OK, "t2w");
        rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
        do_read(16'h0100, 8'd3, 3'd2, 1'b1, OK, "t2r");

        // Out-of-range write must not alias onto word 0
        wdat[0] = 32'hCAFEF00D;
        do_write(16'h0000, 8'd0, -1, OK, "t3w0");
        wdat[0] = 32'h12345678;
        do_write(16'h2000, 8'd0, -1, ERR, "t3wbad");
        rexp[0] = 32'hCAFEF00D;
        do_read(16'h0000, 8'd0, 3'd2, 1'b0, OK, "t3r0");
        rexp[0] = 32'h0;
        do_read(16'h2000, 8'd0, 3'd2, 1'b0, ERR, "t3rbad");

        // Oversized beat and 4 KiB crossing reads
        rexp[0] = 32'h0;
        do_read(16'h0010, 8'd0, 3'd3, 1'b0, ERR, "size_err");
        rexp[0] = 0; rexp[1] = 0; rexp[2] = 0; rexp[3] = 0;
        do_read(16'h0FF8, 8'd3, 3'd2, 1'b0, ERR, "cross4k");

        // Early WLAST
        wdat[0] = 32'h55; wdat[1] = 32'h66; wdat[2] = 32'h77; wdat[3] = 32'h88;
        do_write(16'h0200, 8'd3, 1, ERR, "t4w");

        // Concurrent write and read bursts
        wdat[0] = 32'hA0; wdat[1] = 32'hA1; wdat[2] = 32'hA2; wdat[3] = 32'hA3;
        rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
        fork
            do_write(16'h0300, 8'd3, -1, OK, "t5w");
            do_read(16'h0100, 8'd3, 3'd2, 1'b0, OK, "t5r");
        join
        rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
        do_read(16'h0300, 8'd3, 3'd2, 1'b0, OK, "t5rb");

        // Maximum length burst
        for (int i = 0; i < 256; i++) begin
            wdat[i] = 32'h1000 + i;
            rexp[i] = 32'h1000 + i;
        end
        do_write(16'h0400, 8'd255, -1, OK, "t256w");
        do_read(16'h0400, 8'd255, 3'd2, 1'b0, OK, "t256r");

        // Reset during a read burst
        ARADDR = 16'h0100; ARLEN = 8'd3; ARSIZE = 3'd2; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin tick(); n++; end
        chk("t6_ar_wait", 32'(n < 50), 32'd1);
        tick();
        ARVALID = 1'b0;
        RREADY = 1'b1;
        chk("t6_beat0", RDATA, 32'h11);
        tick();
        chk("t6_beat1", RDATA, 32'h22);
        RREADY = 1'b0;
        #2 ARESTN = 1'b1;
        #1;
        chk("t6_rvalid_rst", 32'(RVAILD), 32'd0);
        chk("t6_arready_rst", 32'(ARREADY), 32'd0);
        chk("t6_rdata_rst", RDATA, 32'd0);
        tick();
        ARESTN = 1'b0;
        tick();
        chk("t6_arready_post", 32'(ARREADY), 32'd1);
        chk("t6_awready_post", 32'(AWREADY), 32'd1);
        chk("t6_rvalid_post", 32'(RVAILD), 32'd0);
        rexp[0] = 32'h22;
        do_read(16'h0104, 8'd0, 3'd2, 1'b0, OK, "t6r");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
